// File: rtl/mxu_skew_feeder.sv
// Operand feeder for the output-stationary systolic MXU: skews A/B lanes diagonally,
// clears the accumulators before a tile, zero-flushes after it and flags completion.
module mxu_skew_feeder #(
    parameter int N  = 128,
    parameter int W  = 16,
    parameter int KW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*W-1:0]    a_vec,
    input  logic [N*W-1:0]    b_vec,
    output logic [N*W-1:0]    row_out,
    output logic [N*W-1:0]    col_out,
    output logic              mxu_clr,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    // Handshake: a beat transfers on a rising clk edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int FW = (N > 1) ? $clog2(2 * N) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 1);

    state_t         state, state_nx;
    logic [KW-1:0]  k_len_q;
    logic [KW-1:0]  beat_cnt;
    logic [FW-1:0]  flush_cnt;
    logic           accept;
    logic           last_beat;
    logic           flush_end;
    logic           in_ready_d, mxu_clr_d, busy_d, done_d;
    logic [N*W-1:0] lane_a_in, lane_b_in;

    assign accept    = in_valid & in_ready;
    assign last_beat = accept && (beat_cnt == (k_len_q - KW'(1)));
    assign flush_end = (flush_cnt == FLUSH_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k_len_q   <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            in_ready  <= 1'b0;
            mxu_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= in_ready_d;
            mxu_clr  <= mxu_clr_d;
            busy     <= busy_d;
            done     <= done_d;
            if (state == S_IDLE && start) begin
                k_len_q <= k_len;
            end
            if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + KW'(1);
            end
            if (state == S_FLUSH) begin
                flush_cnt <= flush_end ? '0 : flush_cnt + FW'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_CLR;
            S_CLR:    state_nx = (k_len_q != '0) ? S_STREAM : S_FLUSH;
            S_STREAM: if (last_beat) state_nx = S_FLUSH;
            S_FLUSH:  if (flush_end) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Decoded from the next state so every control output comes straight off a flop.
    always_comb begin
        in_ready_d = (state_nx == S_STREAM);
        mxu_clr_d  = (state_nx == S_CLR);
        busy_d     = (state_nx != S_IDLE);
        done_d     = (state_nx == S_DONE);
    end

    // Non-beat cycles inject zeros so the diagonal stays aligned and adds nothing.
    assign lane_a_in = accept ? a_vec : '0;
    assign lane_b_in = accept ? b_vec : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] sa [0:i];
        logic [W-1:0] sb [0:i];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) begin
                    sa[k] <= '0;
                    sb[k] <= '0;
                end
            end else begin
                sa[0] <= lane_a_in[i*W +: W];
                sb[0] <= lane_b_in[i*W +: W];
                for (int k = 1; k <= i; k++) begin
                    sa[k] <= sa[k-1];
                    sb[k] <= sb[k-1];
                end
            end
        end

        assign row_out[i*W +: W] = sa[i];
        assign col_out[i*W +: W] = sb[i];
    end

endmodule
